// File: rtl/axi_add_pkg.sv
// Shared types and 7-segment constants for the stream accumulator.
package axi_add_pkg;

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    // Active-high segment codes, bit0=a .. bit6=g
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    // Non-decimal inputs blank the digit
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = SEG_0;
            4'd1:    seg7 = SEG_1;
            4'd2:    seg7 = SEG_2;
            4'd3:    seg7 = SEG_3;
            4'd4:    seg7 = SEG_4;
            4'd5:    seg7 = SEG_5;
            4'd6:    seg7 = SEG_6;
            4'd7:    seg7 = SEG_7;
            4'd8:    seg7 = SEG_8;
            4'd9:    seg7 = SEG_9;
            default: seg7 = 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/axi_add_seg7_decode.sv
// Single-digit BCD to 7-segment decoder (combinational).
module seg7_decode
    import axi_add_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    // Pure lookup through the shared package function
    always_comb begin
        o_seg = seg7(i_digit);
    end

endmodule

// File: rtl/axi_add.sv
// Stream accumulator: sums NUM_COUNT accepted beats and presents the
// sum mod 100 as two registered 7-segment digits on a valid/ready port.
module axi_add
    import axi_add_pkg::*;
#(
    parameter int NUM_COUNT = 8,
    parameter int W_DATA    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [W_DATA-1:0] data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [6:0]        m_data_ones,
    output logic [6:0]        m_data_tens
);

    // Exact no-overflow sum width, widened to at least 7 bits so the
    // constant 100 fits in the mod arithmetic.
    localparam int W_RAW = $clog2(NUM_COUNT * (2**W_DATA - 1) + 1);
    localparam int W_SUM = (W_RAW < 7) ? 7 : W_RAW;
    localparam int W_CNT = (NUM_COUNT > 1) ? $clog2(NUM_COUNT) : 1;

    state_t             r_state;
    state_t             w_next;
    logic               r_live;
    logic [W_CNT-1:0]   r_count;
    logic [W_SUM-1:0]   r_sum;
    logic [W_SUM-1:0]   w_sum_next;
    logic [W_SUM-1:0]   w_mod100;
    logic [3:0]         w_ones;
    logic [3:0]         w_tens;
    logic [6:0]         w_seg_ones;
    logic [6:0]         w_seg_tens;
    logic [6:0]         r_ones;
    logic [6:0]         r_tens;
    logic               w_beat;
    logic               w_last;
    logic               w_take;

    assign w_beat     = s_valid && s_ready;
    assign w_last     = (r_count == W_CNT'(NUM_COUNT - 1));
    assign w_take     = m_valid && m_ready;
    assign w_sum_next = r_sum + W_SUM'(data);

    // Digits come from the sum including the beat being accepted now
    assign w_mod100 = w_sum_next % W_SUM'(100);
    assign w_ones   = 4'(w_mod100 % W_SUM'(10));
    assign w_tens   = 4'(w_mod100 / W_SUM'(10));

    seg7_decode u_seg_ones (.i_digit(w_ones), .o_seg(w_seg_ones));
    seg7_decode u_seg_tens (.i_digit(w_tens), .o_seg(w_seg_tens));

    assign m_data_ones = r_ones;
    assign m_data_tens = r_tens;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_ACC;
        else        r_state <= w_next;
    end

    // Next-state: leave ACC on the final beat, leave OUT on handshake
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_ACC:  if (w_beat && w_last) w_next = ST_OUT;
            ST_OUT:  if (m_ready)          w_next = ST_ACC;
            default: w_next = ST_ACC;
        endcase
    end

    // Outputs: r_live keeps s_ready low until the first edge after reset
    always_comb begin
        s_ready = (r_state == ST_ACC) && r_live;
        m_valid = (r_state == ST_OUT);
    end

    // Accumulator, beat counter and registered digit codes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_live  <= 1'b0;
            r_count <= '0;
            r_sum   <= '0;
            r_ones  <= SEG_0;
            r_tens  <= SEG_0;
        end else begin
            r_live <= 1'b1;
            if (w_beat) begin
                r_sum <= w_sum_next;
                if (w_last) begin
                    r_count <= '0;
                    r_ones  <= w_seg_ones;
                    r_tens  <= w_seg_tens;
                end else begin
                    r_count <= r_count + W_CNT'(1);
                end
            end
            if (w_take) r_sum <= '0;
        end
    end

endmodule

// File: tb/tb_axi_add.sv
// Directed bench for axi_add: inputs change and outputs are sampled on
// the falling edge, so every posedge sees stable stimulus.
module tb_axi_add;

    logic       clk;
    logic       reset;
    logic [7:0] data;
    logic       s_valid;
    logic       s_ready;
    logic       m_valid;
    logic       m_ready;
    logic [6:0] m_data_ones;
    logic [6:0] m_data_tens;

    int n_cmp = 0;
    int n_err = 0;

    axi_add #(.NUM_COUNT(8), .W_DATA(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .data        (data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data_ones (m_data_ones),
        .m_data_tens (m_data_tens)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One beat presented for one posedge; checks it will be accepted
    task automatic beat(input logic [7:0] d);
        chk("beat_rdy", 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        data    = d;
        @(negedge clk);
        s_valid = 1'b0;
        data    = 8'hAA;
    endtask

    task automatic chk_result(input string tag, input logic [6:0] tens, input logic [6:0] ones);
        chk({tag, "_mvalid"}, 32'(m_valid), 32'd1);
        chk({tag, "_sready"}, 32'(s_ready), 32'd0);
        chk({tag, "_tens"}, 32'(m_data_tens), 32'(tens));
        chk({tag, "_ones"}, 32'(m_data_ones), 32'(ones));
    endtask

    // With m_ready high the handshake takes one edge, then ACC resumes
    task automatic chk_resume(input string tag);
        @(negedge clk);
        chk({tag, "_mvalid0"}, 32'(m_valid), 32'd0);
        chk({tag, "_sready1"}, 32'(s_ready), 32'd1);
    endtask

    initial begin
        reset   = 1'b0;
        data    = 8'h00;
        s_valid = 1'b0;
        m_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_sready", 32'(s_ready), 32'd0);
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk("rst_ones", 32'(m_data_ones), 32'h3F);
        chk("rst_tens", 32'(m_data_tens), 32'h3F);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_sready", 32'(s_ready), 32'd1);

        // 8 x 7 = 56
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) beat(8'd7);
        chk_result("b7", 7'h6D, 7'h7D);
        chk_resume("b7");

        // Same with 5 cycles of backpressure; s_valid held high to prove no accept
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) beat(8'd7);
        s_valid = 1'b1;
        data    = 8'd99;
        for (int c = 0; c < 5; c++) begin
            chk_result("bp", 7'h6D, 7'h7D);
            @(negedge clk);
        end
        chk_result("bp_end", 7'h6D, 7'h7D);
        s_valid = 1'b0;
        m_ready = 1'b1;
        chk_resume("bp");
        chk("bp_hold_ones", 32'(m_data_ones), 32'h7D);
        chk("bp_hold_tens", 32'(m_data_tens), 32'h6D);

        // 200 x 8 = 1600 -> 00
        for (int i = 0; i < 8; i++) beat(8'd200);
        chk_result("b200", 7'h3F, 7'h3F);
        chk_resume("b200");

        // 1..8 = 36 (also confirms the previous sum was cleared)
        for (int i = 1; i <= 8; i++) beat(8'(i));
        chk_result("seq", 7'h4F, 7'h7D);
        chk_resume("seq");

        // 9 x 8 with idle gaps carrying junk data -> 72
        for (int i = 0; i < 8; i++) begin
            beat(8'd9);
            if (i < 7) begin
                data = 8'd50;
                @(negedge clk);
                chk("gap_mvalid", 32'(m_valid), 32'd0);
            end
        end
        chk_result("gap", 7'h07, 7'h5B);
        chk_resume("gap");

        // 4 beats, reset pulse, then 8 x 1 -> 08
        for (int i = 0; i < 4; i++) beat(8'd50);
        reset = 1'b0;
        #1;
        chk("mid_rst_sready", 32'(s_ready), 32'd0);
        chk("mid_rst_mvalid", 32'(m_valid), 32'd0);
        chk("mid_rst_ones", 32'(m_data_ones), 32'h3F);
        chk("mid_rst_tens", 32'(m_data_tens), 32'h3F);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst2_sready", 32'(s_ready), 32'd1);
        for (int i = 0; i < 8; i++) beat(8'd1);
        chk_result("b1", 7'h3F, 7'h7F);
        chk_resume("b1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
